fmul_pipe: RTL and testbench



---
 rtl/fmul_pipe.sv | 183 ++++++++++++++++++
 tb/tb_fmul_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_pipe.sv
// Pipelined IEEE-754 binary32 multiplier: valid/ready backpressure, RNE rounding, FTZ, {nv,ovf,udf} flags.
// Three logical steps (unpack/multiply, normalise/sticky, round/pack) are spread over STAGES registers.
module fmul_pipe #(
  parameter int STAGES = 3,
  parameter bit FTZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic [2:0]  flags
);
  typedef enum logic [1:0] {CLS_NUM, CLS_NAN, CLS_INF, CLS_ZERO} cls_e;

  typedef struct packed {
    logic              sgn;
    cls_e              cls;
    logic signed [9:0] exp;
    logic [47:0]       prod;
  } s1_t;

  typedef struct packed {
    logic              sgn;
    cls_e              cls;
    logic signed [9:0] exp;
    logic [23:0]       man;
    logic              grd;
    logic              stk;
  } s2_t;

  typedef struct packed {
    logic [31:0] y;
    logic [2:0]  flags;
  } res_t;

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("fmul_pipe: STAGES must be in 1..4");
  end
  if (FTZ != 1'b1) begin : g_bad_ftz
    $error("fmul_pipe: FTZ=0 is reserved");
  end

  // Exponent field 0 reads as signed zero whatever the fraction holds.
  function automatic s1_t f_unpack(input logic [31:0] a, input logic [31:0] b);
    s1_t  s;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    s.sgn  = a[31] ^ b[31];
    s.exp  = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    s.prod = 48'({~a_zero, a[22:0]}) * 48'({~b_zero, b[22:0]});
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) s.cls = CLS_NAN;
    else if (a_inf || b_inf)                                       s.cls = CLS_INF;
    else if (a_zero || b_zero)                                     s.cls = CLS_ZERO;
    else                                                           s.cls = CLS_NUM;
    return s;
  endfunction

  function automatic s2_t f_norm(input s1_t p);
    s2_t s;
    s.sgn = p.sgn;
    s.cls = p.cls;
    if (p.prod[47]) begin
      s.exp = p.exp + 10'sd1;
      s.man = p.prod[47:24];
      s.grd = p.prod[23];
      s.stk = |p.prod[22:0];
    end else begin
      s.exp = p.exp;
      s.man = p.prod[46:23];
      s.grd = p.prod[22];
      s.stk = |p.prod[21:0];
    end
    return s;
  endfunction

  function automatic res_t f_round(input s2_t p);
    res_t              r;
    logic [24:0]       m;
    logic signed [9:0] e;
    logic              inc;
    inc = p.grd & (p.stk | p.man[0]);
    m   = {1'b0, p.man} + {24'd0, inc};
    e   = p.exp;
    if (m[24]) e = e + 10'sd1;
    r.y     = {p.sgn, e[7:0], (m[24] ? m[23:1] : m[22:0])};
    r.flags = 3'b000;
    case (p.cls)
      CLS_NAN: begin
        r.y     = 32'h7FC0_0000;
        r.flags = 3'b100;
      end
      CLS_INF:  r.y = {p.sgn, 8'hFF, 23'd0};
      CLS_ZERO: r.y = {p.sgn, 31'd0};
      default: begin
        if (e >= 10'sd255) begin
          r.y     = {p.sgn, 8'hFF, 23'd0};
          r.flags = 3'b010;
        end else if (e <= 10'sd0) begin
          r.y     = {p.sgn, 31'd0};
          r.flags = 3'b001;
        end
      end
    endcase
    return r;
  endfunction

  logic              adv;
  logic [STAGES:1]   vld_pipe_d, vld_pipe_q;
  s1_t               s1_c;
  s2_t               s2_c;
  res_t              rnd_c, out_c, res_d, res_q;

  // All stages move together; a stalled output freezes the whole pipe.
  assign out_valid = vld_pipe_q[STAGES];
  assign in_ready  = !out_valid || out_ready;
  assign adv       = in_ready;
  assign s1_c      = f_unpack(x1, x2);

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (adv) begin
      vld_pipe_d    = vld_pipe_q << 1;
      vld_pipe_d[1] = in_valid;
    end
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) vld_pipe_q <= '0;
    else       vld_pipe_q <= vld_pipe_d;

  if (STAGES >= 2) begin : g_s1_reg
    s1_t s1_d, s1_q;
    always_comb s1_d = adv ? s1_c : s1_q;
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) s1_q <= '0;
      else       s1_q <= s1_d;
    assign s2_c = f_norm(s1_q);
  end else begin : g_s1_comb
    assign s2_c = f_norm(s1_c);
  end

  if (STAGES >= 3) begin : g_s2_reg
    s2_t s2_d, s2_q;
    always_comb s2_d = adv ? s2_c : s2_q;
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) s2_q <= '0;
      else       s2_q <= s2_d;
    assign rnd_c = f_round(s2_q);
  end else begin : g_s2_comb
    assign rnd_c = f_round(s2_c);
  end

  // A fourth stage only retimes the packed result ahead of the output register.
  if (STAGES == 4) begin : g_s3_reg
    res_t s3_d, s3_q;
    always_comb s3_d = adv ? rnd_c : s3_q;
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) s3_q <= '0;
      else       s3_q <= s3_d;
    assign out_c = s3_q;
  end else begin : g_s3_comb
    assign out_c = rnd_c;
  end

  always_comb res_d = adv ? out_c : res_q;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) res_q <= '0;
    else       res_q <= res_d;

  assign y     = res_q.y;
  assign flags = res_q.flags;
endmodule

// File: tb/tb_fmul_pipe.sv
// Scoreboard bench for fmul_pipe: driver pushes expected results, an independent monitor pops and compares.
module tb_fmul_pipe;
  localparam int STAGES = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] x1, x2, y;
  logic [2:0]  flags;

  int          total = 0;
  int          bad   = 0;
  logic [34:0] sb [$];

  fmul_pipe #(.STAGES(STAGES), .FTZ(1'b1)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .x1(x1), .x2(x2),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: exact product in double precision, then RNE to 24 bits with unbounded exponent.
  function automatic real mag(input logic [31:0] v);
    return real'({1'b1, v[22:0]}) * (2.0 ** (real'(int'(v[30:23])) - 150.0));
  endfunction

  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic        an, bn, ai, bi, az, bz;
    logic [63:0] pb;
    logic [22:0] frac;
    logic [28:0] rem;
    int          e;
    s  = a[31] ^ b[31];
    az = (a[30:23] == 8'd0);
    bz = (b[30:23] == 8'd0);
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (an || bn || (ai && bz) || (bi && az)) return {32'h7FC00000, 3'b100};
    if (ai || bi) return {s, 8'hFF, 23'd0, 3'b000};
    if (az || bz) return {s, 31'd0, 3'b000};
    pb   = $realtobits(mag(a) * mag(b));
    e    = int'(pb[62:52]) - 1023 + 127;
    frac = pb[51:29];
    rem  = pb[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && frac[0])) begin
      frac = frac + 23'd1;
      if (frac == 23'd0) e++;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0, 3'b010};
    if (e <= 0)   return {s, 31'd0, 3'b001};
    return {s, 8'(e), frac, 3'b000};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: ;
      1, 2: r[30:23] = 8'($urandom_range(100, 154));
      default: r[30:23] = 8'($urandom_range(1, 254));
    endcase
    return r;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [34:0] exp);
    int n = 0;
    in_valid = 1'b1; x1 = a; x2 = b;
    #1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #2; n++;
    end
    @(posedge clk); #1;
    sb.push_back(exp);
    in_valid = 1'b0;
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, want accept", n);
    end
  endtask

  task automatic wait_latency();
    int lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", 64'(lat), 64'(STAGES));
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check("drain_outstanding", 64'(sb.size()), 64'd0);
  endtask

  task automatic stream(input int n, input bit rnd);
    int          i = 0;
    int          cyc = 0;
    bit          acc;
    logic [31:0] a, b;
    a = rand_op(); b = rand_op();
    while (i < n && cyc < 20 * n + 100) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 4 && cyc <= 6);
      in_valid = 1'b1; x1 = a; x2 = b;
      #1; acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sb.push_back(model(a, b));
        i++;
        a = rand_op(); b = rand_op();
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    if (i < n) begin
      total++; bad++;
      $display("FAIL stream_timeout: accepted %0d of %0d ops", i, n);
    end
  endtask

  initial begin : monitor
    logic [34:0] expv;
    logic [34:0] prev_res;
    bit          prev_stall;
    prev_stall = 1'b0;
    prev_res   = '0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (prev_stall && out_valid) check("hold_stable", 64'({y, flags}), 64'(prev_res));
        if (out_valid && !out_ready) check("in_ready_stall", 64'(in_ready), 64'd0);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_out: y=%h flags=%b with nothing outstanding", y, flags);
          end else begin
            expv = sb.pop_front();
            check("result", 64'({y, flags}), 64'(expv));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_res   = {y, flags};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] da [0:12];
    logic [31:0] db [0:12];
    logic [34:0] de [0:12];
    da = '{32'h3FC00000, 32'h3F800001, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 32'h7FA00000, 32'hFF800000,
           32'h00800000, 32'h80800000, 32'h00000001, 32'h00000000, 32'h80000000, 32'hFFC00000};
    db = '{32'h40000000, 32'h3F800001, 32'h40000000, 32'h40000000, 32'h00000000, 32'h3F800000, 32'h40000000,
           32'h3F000000, 32'h3F000000, 32'h7F000000, 32'hFF800000, 32'h3F800000, 32'h3F800000};
    de = '{{32'h40400000, 3'b000}, {32'h3F800002, 3'b000}, {32'h7F800000, 3'b010}, {32'hFF800000, 3'b010},
           {32'h7FC00000, 3'b100}, {32'h7FC00000, 3'b100}, {32'hFF800000, 3'b000}, {32'h00000000, 3'b001},
           {32'h80000000, 3'b001}, {32'h00000000, 3'b000}, {32'h7FC00000, 3'b100}, {32'h80000000, 3'b000},
           {32'h7FC00000, 3'b100}};

    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x1 = '0; x2 = '0;
    @(posedge clk); #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_y", 64'(y), 64'd0);
    check("reset_flags", 64'(flags), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #3;
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      send(da[i], db[i], de[i]);
      wait_latency();
      drain();
    end

    stream(8, 1'b0);
    drain();
    stream(300, 1'b1);
    drain();

    out_ready = 1'b0;
    repeat (3) begin
      in_valid = 1'b1; x1 = rand_op(); x2 = rand_op();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_y", 64'(y), 64'd0);
    check("async_rst_flags", 64'(flags), 64'd0);
    sb.delete();
    @(posedge clk); #3;
    rstn = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    send(32'h3F800000, 32'h3F800000, {32'h3F800000, 3'b000});
    wait_latency();
    drain();
    repeat (STAGES + 6) @(posedge clk);
    #1;
    check("post_reset_idle", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
